// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared widths, FSM state encoding and command record for the
//               ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int OPND_W = 16;
    localparam int OPC_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic              c;
        logic [OPC_W-1:0]  opc;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage
`default_nettype wire

// File: rtl/alu_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_fifo
// Description : Command FIFO, DEPTH entries (power of two) of WIDTH bits.
//               Full FIFO refuses pushes even when a pop happens in the
//               same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Queues ALU commands, presents each to an external
//               combinational ALU for SETTLE cycles, captures the result and
//               holds it until the consumer accepts it.
//               Optional feature macro: ALU_SEQ_STICKY_EN (sticky flags).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    input  logic              cmd_c,
    input  logic [OPC_W-1:0]  cmd_opc,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic              alu_c,
    output logic [OPC_W-1:0]  alu_opc,
    input  logic [OPND_W-1:0] alu_w,
    input  logic              alu_zer,
    input  logic              alu_neg,
    output logic [OPND_W-1:0] res_w,
    output logic              res_zer,
    output logic              res_neg,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic [15:0]       op_count,
    output logic              sticky_zer,
    output logic              sticky_neg,
    input  logic              clr_sticky
);

    localparam int             CNT_W       = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE);

    cmd_t              w_cmd_in;
    cmd_t              w_head;
    logic [CMD_W-1:0]  w_head_bits;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_capture;
    logic              w_ack;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    cmd_t              r_alu;
    logic [OPND_W-1:0] r_res_w;
    logic              r_res_zer;
    logic              r_res_neg;
    logic              r_res_valid;
    logic [15:0]       r_op_count;

    assign w_cmd_in = '{a: cmd_a, b: cmd_b, c: cmd_c, opc: cmd_opc};
    assign w_push   = cmd_valid & ~w_full;
    assign w_head   = cmd_t'(w_head_bits);

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand registers and settle counter; operands change only on a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu <= '0;
            r_cnt <= '0;
        end else if (w_pop) begin
            r_alu <= w_head;
            r_cnt <= SETTLE_INIT;
        end else if (r_state == ST_SETTLE) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result capture, result handshake and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_w     <= '0;
            r_res_zer   <= 1'b0;
            r_res_neg   <= 1'b0;
            r_res_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_capture) begin
                r_res_w     <= alu_w;
                r_res_zer   <= alu_zer;
                r_res_neg   <= alu_neg;
                r_res_valid <= 1'b1;
            end else if (w_ack) begin
                r_res_valid <= 1'b0;
                r_op_count  <= r_op_count + 16'd1;
            end
        end
    end

`ifdef ALU_SEQ_STICKY_EN
    logic r_sticky_zer;
    logic r_sticky_neg;

    // Sticky flags accumulate each capture; a capture outranks a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_zer <= 1'b0;
            r_sticky_neg <= 1'b0;
        end else if (w_capture) begin
            r_sticky_zer <= r_sticky_zer | alu_zer;
            r_sticky_neg <= r_sticky_neg | alu_neg;
        end else if (clr_sticky) begin
            r_sticky_zer <= 1'b0;
            r_sticky_neg <= 1'b0;
        end
    end

    assign sticky_zer = r_sticky_zer;
    assign sticky_neg = r_sticky_neg;
`else
    logic w_unused_clr_sticky;

    assign w_unused_clr_sticky = clr_sticky;
    assign sticky_zer          = 1'b0;
    assign sticky_neg          = 1'b0;
`endif

    assign cmd_ready = ~w_full;
    assign busy      = (r_state != ST_IDLE) | ~w_empty;
    assign alu_a     = r_alu.a;
    assign alu_b     = r_alu.b;
    assign alu_c     = r_alu.c;
    assign alu_opc   = r_alu.opc;
    assign res_w     = r_res_w;
    assign res_zer   = r_res_zer;
    assign res_neg   = r_res_neg;
    assign res_valid = r_res_valid;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a behavioural
//               ALU, a result-queue model and directed vectors.
//               Honours ALU_SEQ_STICKY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd_a, cmd_b;
    logic        cmd_c;
    logic [2:0]  cmd_opc;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] alu_a, alu_b;
    logic        alu_c;
    logic [2:0]  alu_opc;
    logic [15:0] alu_w;
    logic        alu_zer, alu_neg;
    logic [15:0] res_w;
    logic        res_zer, res_neg, res_valid, res_ready;
    logic        busy;
    logic [15:0] op_count;
    logic        sticky_zer, sticky_neg, clr_sticky;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_c      (cmd_c),
        .cmd_opc    (cmd_opc),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_opc    (alu_opc),
        .alu_w      (alu_w),
        .alu_zer    (alu_zer),
        .alu_neg    (alu_neg),
        .res_w      (res_w),
        .res_zer    (res_zer),
        .res_neg    (res_neg),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .op_count   (op_count),
        .sticky_zer (sticky_zer),
        .sticky_neg (sticky_neg),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    // Behavioural external ALU.
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic [2:0] opc);
        case (opc)
            3'd0:    return a + b + {15'd0, c};
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_w   = alu_f(alu_a, alu_b, alu_c, alu_opc);
    assign alu_zer = (alu_w == 16'h0000);
    assign alu_neg = alu_w[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: results of accepted, not-yet-acknowledged commands in order.
    typedef struct {
        logic [15:0] w;
        logic        z;
        logic        n;
    } res_t;

    res_t        pend[$];
    logic [15:0] m_cnt = 16'd0;

    // Compare on the falling edge, then apply the handshakes the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            m_cnt = 16'd0;
        end
        chk("busy", {31'd0, busy}, {31'd0, pend.size() != 0});
        chk("op_count", {16'd0, op_count}, {16'd0, m_cnt});
        if (res_valid) begin
            chk("res_valid_has_pending", {31'd0, pend.size() != 0}, 32'd1);
            if (pend.size() != 0) begin
                chk("res_w", {16'd0, res_w}, {16'd0, pend[0].w});
                chk("res_zer", {31'd0, res_zer}, {31'd0, pend[0].z});
                chk("res_neg", {31'd0, res_neg}, {31'd0, pend[0].n});
            end
        end
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                res_t r;
                r.w = alu_f(cmd_a, cmd_b, cmd_c, cmd_opc);
                r.z = (r.w == 16'h0000);
                r.n = r.w[15];
                pend.push_back(r);
            end
            if (res_valid && res_ready && pend.size() != 0) begin
                void'(pend.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one command; returns 1 ns after the accepting edge.
    task automatic push_cmd(input logic [15:0] a, input logic [15:0] b,
                            input logic c, input logic [2:0] opc);
        bit done;
        bit rdy;
        done      = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_c     = c;
        cmd_opc   = opc;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
        end
        #1;
        cmd_valid = 1'b0;
        chk("push_accepted", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        chk("res_valid_arrives", {31'd0, ok}, 32'd1);
    endtask

    task automatic ack();
        res_ready = 1'b1;
        cyc(1);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit idle_ok;
        rst        = 1'b1;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_c      = 1'b0;
        cmd_opc    = '0;
        cmd_valid  = 1'b0;
        res_ready  = 1'b0;
        clr_sticky = 1'b0;
        cyc(2);

        // Reset values
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu", {alu_a, alu_b}, 32'd0);
        chk("rst_alu_c_opc", {28'd0, alu_c, alu_opc}, 32'd0);
        chk("rst_res", {13'd0, res_w, res_zer, res_neg, op_count[0]}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_sticky", {30'd0, sticky_zer, sticky_neg}, 32'd0);
        rst = 1'b0;
        cyc(1);

        // Single command: operands one edge after acceptance, result after E0+2
        push_cmd(16'hFE37, 16'h001C, 1'b1, 3'd0);
        cyc(1);
        chk("alu_a_load", {16'd0, alu_a}, 32'h0000FE37);
        chk("alu_b_load", {16'd0, alu_b}, 32'h0000001C);
        chk("alu_c_opc_load", {28'd0, alu_c, alu_opc}, 32'h00000008);
        chk("res_valid_e0p1", {31'd0, res_valid}, 32'd0);
        cyc(1);
        chk("res_valid_e0p2", {31'd0, res_valid}, 32'd1);
        chk("res_w_add", {16'd0, res_w}, 32'h0000FE54);
        chk("res_flags_add", {30'd0, res_zer, res_neg}, 32'd1);
        ack();
        chk("op_count_1", {16'd0, op_count}, 32'd1);

        // Zero and negative results
        push_cmd(16'h1234, 16'h1234, 1'b0, 3'd4);
        wait_valid();
        chk("res_w_zero", {16'd0, res_w}, 32'h00000000);
        chk("res_flags_zero", {30'd0, res_zer, res_neg}, 32'd2);
        ack();
        push_cmd(16'h8000, 16'h0001, 1'b0, 3'd3);
        wait_valid();
        chk("res_w_neg", {16'd0, res_w}, 32'h00008001);
        chk("res_flags_neg", {30'd0, res_zer, res_neg}, 32'd1);
        ack();
        cyc(3);
`ifdef ALU_SEQ_STICKY_EN
        chk("sticky_accum", {30'd0, sticky_zer, sticky_neg}, 32'd3);
`else
        chk("sticky_off", {30'd0, sticky_zer, sticky_neg}, 32'd0);
`endif
        clr_sticky = 1'b1;
        cyc(1);
        clr_sticky = 1'b0;
        chk("sticky_cleared", {30'd0, sticky_zer, sticky_neg}, 32'd0);

        // Fill: one in HOLD plus DEPTH queued, then refuse further pushes
        for (int i = 0; i < 5; i++) begin
            push_cmd(16'(i + 1), 16'h0010, 1'b0, 3'd0);
        end
        cyc(2);
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_res_valid", {31'd0, res_valid}, 32'd1);
        cmd_a     = 16'hDEAD;
        cmd_b     = 16'h0000;
        cmd_opc   = 3'd0;
        cmd_valid = 1'b1;
        cyc(3);
        cmd_valid = 1'b0;
        chk("refused_cmd_ready", {31'd0, cmd_ready}, 32'd0);

        // Result held stable while res_ready stays low
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("hold_res_w", {16'd0, res_w}, 32'h00000011);
            chk("hold_op_count", {16'd0, op_count}, 32'd3);
        end
        ack();
        chk("pulse_op_count", {16'd0, op_count}, 32'd4);

        // Drain the rest in push order
        res_ready = 1'b1;
        idle_ok   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (!busy) begin
                idle_ok = 1'b1;
                break;
            end
        end
        res_ready = 1'b0;
        chk("drain_idle", {31'd0, idle_ok}, 32'd1);
        chk("drain_op_count", {16'd0, op_count}, 32'd8);

        // Reset during SETTLE with two commands queued
        for (int i = 0; i < 4; i++) begin
            push_cmd(16'h0020 + 16'(i), 16'h0001, 1'b0, 3'd1);
        end
        wait_valid();
        ack();
        cyc(1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("midrst_op_count", {16'd0, op_count}, 32'd0);
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("post_rst_no_result", {30'd0, res_valid, busy}, 32'd0);
        end

        // Operation resumes after reset
        push_cmd(16'h0007, 16'h0003, 1'b0, 3'd1);
        wait_valid();
        chk("post_rst_res_w", {16'd0, res_w}, 32'h00000004);
        ack();
        chk("post_rst_op_count", {16'd0, op_count}, 32'd1);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set command FIFO entries (power of two, >=2).
REQ-002 Parameter SETTLE, default 1, SHALL set the number of cycles ALU operands are held before capture (>=1).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Ports cmd_a and cmd_b, inputs, 16 each: signed command operands A and B.
REQ-006 Ports cmd_c (input, 1) and cmd_opc (input, 3): command carry-in and opcode.
REQ-007 Ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-008 Ports alu_a and alu_b, outputs, 16 each: registered operands driven to the external ALU.
REQ-009 Ports alu_c (output, 1) and alu_opc (output, 3): registered carry-in and opcode to the ALU.
REQ-010 Ports alu_w (input, 16), alu_zer (input, 1), alu_neg (input, 1): combinational ALU response.
REQ-011 Ports res_w (output, 16), res_zer (output, 1), res_neg (output, 1): captured result.
REQ-012 Ports res_valid (output, 1) and res_ready (input, 1): result handshake.
REQ-013 Port busy, output, 1: high whenever the FSM is not in IDLE or the FIFO is non-empty.
REQ-014 Port op_count, output, 16: count of completed result handshakes.
REQ-015 Ports sticky_zer and sticky_neg (outputs, 1 each) and clr_sticky (input, 1): sticky flags, see Configuration.

Function
REQ-016 A command SHALL be accepted on an edge where cmd_valid=1 and cmd_ready=1. cmd_ready SHALL be high exactly when the FIFO is not full.
REQ-017 The FIFO SHALL be first-in first-out. A full FIFO SHALL refuse pushes, with no bypass even when a pop occurs in the same cycle.
REQ-018 The FSM SHALL have three states: IDLE, SETTLE and HOLD.
REQ-019 IDLE with the FIFO non-empty: the next edge SHALL pop the FIFO head, load alu_* and enter SETTLE with a counter set to SETTLE.
REQ-020 SETTLE: each edge SHALL decrement the counter. The edge on which the counter equals 1 SHALL:
  - register alu_w, alu_zer and alu_neg into res_*;
  - set res_valid;
  - enter HOLD.
REQ-021 alu_* SHALL stay stable from load until the next pop. res_* SHALL stay stable while res_valid=1.
REQ-022 HOLD: on an edge with res_ready=1, the FSM SHALL clear res_valid, increment op_count and return to IDLE. Otherwise it SHALL remain in HOLD.
REQ-023 Latency: a command accepted at edge E0 into an idle block with an empty FIFO SHALL give res_valid=1 after edge E0+1+SETTLE.
REQ-024 op_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-025 A push and a pop in the same cycle on a non-full FIFO SHALL both take effect, leaving the occupancy unchanged.

Reset
REQ-026 When rst asserts, outputs SHALL go immediately to these values:
  - FIFO empty, FSM in IDLE;
  - res_valid=0 and busy=0;
  - alu_a, alu_b, alu_c, alu_opc, res_w, res_zer, res_neg, op_count and sticky flags all 0;
  - cmd_ready=1.
REQ-027 Reset mid-operation SHALL discard queued commands and any unacknowledged result, and no late res_valid pulse SHALL follow.

Configuration
REQ-028 With macro ALU_SEQ_STICKY_EN defined:
  - sticky_zer and sticky_neg SHALL OR-accumulate res_zer and res_neg at each capture;
  - clr_sticky=1 SHALL clear them on the next edge, with a simultaneous capture taking priority.
REQ-029 Without ALU_SEQ_STICKY_EN, sticky_zer and sticky_neg SHALL be constant 0 and clr_sticky SHALL be ignored.

Structure
REQ-030 Package alu_seq_pkg SHALL hold:
  - operand width (16) and opcode width (3) constants;
  - the FSM state enum;
  - a packed command struct {a, b, c, opc}.
REQ-031 The FIFO SHALL be a sub-module named alu_seq_fifo, parameterised by DEPTH and the struct type width.

Verification
REQ-032 Single command A=16'hFE37, B=16'h001C, C=1, opc=0, with a bench ALU model → alu_* equal these values one edge after acceptance; res_w equals the model output after edge E0+2.
REQ-033 Bench ALU returns alu_w=16'h0000 → res_zer=1, res_neg=0. It returns 16'h8001 → res_neg=1, res_zer=0.
REQ-034 Push 5 commands with res_ready=0 and DEPTH=4 → 1 command in HOLD plus 4 in the FIFO, cmd_ready=0. Results then drain in push order.
REQ-035 Hold res_ready=0 for 10 cycles after res_valid → res_* stable and op_count unchanged. Pulse res_ready → op_count+1.
REQ-036 Assert rst during SETTLE with 2 commands queued → busy=0 and res_valid=0 immediately, and no result appears afterwards.
REQ-037 ALU_SEQ_STICKY_EN defined: a zero result followed by a non-zero result → sticky_zer stays 1 until clr_sticky is pulsed.
